// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared definitions for the bus-to-SRAM controller.
//   - state_e             : controller FSM states
//   - DEFAULT_WAIT_STATES : default number of strobe-low (ACCESS) cycles
//   - ADDR_EXT_W          : zero-extension bits prepended to the 16-bit word
//                           address to form the 20-bit SRAM address
//   - lane_mask()         : expands a 2-bit lane enable into a 16-bit mask
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEFAULT_WAIT_STATES = 1;
    localparam int ADDR_EXT_W          = 4;

    // bit1 enables [15:8], bit0 enables [7:0]
    function automatic logic [15:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl
//   Synchronous controller between the LC-3 memory interface (MAR/MDR,
//   MIO_EN, R.W) and an external asynchronous 16-bit SRAM. A single-cycle
//   request is turned into a SETUP / ACCESS (WAIT_STATES cycles) / DONE
//   strobe sequence on the active-low CE/OE/WE/LB/UB pins. DONE raises
//   Ready for one cycle, which the CPU FSM uses as its memory-ready (R).
//
//   Handshake: Req is sampled only while the controller is IDLE; a sampled
//   Req captures Wr/Addr/WData (and ByteEn) and commits to exactly one
//   access. Req seen in any other state is dropped, never queued. Ready is
//   a one-cycle completion pulse; for reads RData is valid from that cycle
//   until the next read completes. Busy is high in every non-IDLE state.
//
// Parameters
//   WAIT_STATES   cycles the OE or WE strobe is held low, 1..15
//
// Ports
//   Clk            in   system clock, rising edge
//   Reset          in   synchronous active-high reset
//   Req            in   access request
//   Wr             in   1 = write, 0 = read
//   Addr[15:0]     in   word address
//   WData[15:0]    in   write data
//   ByteEn[1:0]    in   lane enables (only with SRAM_CTRL_BYTE_EN defined)
//   RData[15:0]    out  registered read data
//   Ready          out  one-cycle completion pulse
//   Busy           out  controller not IDLE
//   CE,OE,WE,LB,UB out  active-low SRAM strobes
//   ADDR[19:0]     out  SRAM address, zero-extended captured Addr
//   DQ[15:0]       io   SRAM data bus, driven only during writes
//   dbg_state_o    out  current FSM state (state_e encoding)
//   dbg_dq_oe_o    out  1 while this block drives DQ
//
// Build option
//   SRAM_CTRL_BYTE_EN  adds the ByteEn port and per-lane LB/UB control;
//                      without it every access is a full 16-bit word.
//
// Every pin output is either a register or a decode of registered state, so
// there is no combinational path from Req/Addr/WData to the SRAM.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
`ifdef SRAM_CTRL_BYTE_EN
    input  logic [1:0]  ByteEn,
`endif
    output logic [15:0] RData,
    output logic        Ready,
    output logic        Busy,
    output logic        CE,
    output logic        OE,
    output logic        WE,
    output logic        LB,
    output logic        UB,
    output logic [19:0] ADDR,
    inout  wire  [15:0] DQ,
    output logic [1:0]  dbg_state_o,
    output logic        dbg_dq_oe_o
);

    // Out-of-range wait counts would truncate the 4-bit counter load.
    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("sram_ctrl: WAIT_STATES must be in 1..15");
    end

    // Counter load value: ACCESS ends on the cycle the counter reads zero,
    // so loading WAIT_STATES-1 gives exactly WAIT_STATES ACCESS cycles.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        wr_q,    wr_d;
    logic [15:0] addr_q,  addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
`ifdef SRAM_CTRL_BYTE_EN
    logic [1:0]  be_q,    be_d;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
`ifdef SRAM_CTRL_BYTE_EN
            be_q    <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef SRAM_CTRL_BYTE_EN
            be_q    <= be_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_CTRL_BYTE_EN
        be_d    = be_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    wr_d    = Wr;
                    addr_d  = Addr;
                    wdata_d = WData;
`ifdef SRAM_CTRL_BYTE_EN
                    be_d    = ByteEn;
`endif
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                cnt_d   = WAIT_LAST;
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Last strobe-low cycle: the SRAM output has had the
                    // whole ACCESS window to settle, so sample it here.
                    // Writes never touch RData.
                    if (!wr_q) begin
`ifdef SRAM_CTRL_BYTE_EN
                        rdata_d = DQ & lane_mask(be_q);
`else
                        rdata_d = DQ;
`endif
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pin decode (from registered state only)
    // ------------------------------------------------------------------
    logic in_access;
    logic dq_oe;

    assign in_access = (state_q == ST_ACCESS);

    // CE covers SETUP..DONE so address/data have setup and hold around the
    // OE/WE pulse. OE and WE are mutually exclusive through wr_q.
    assign CE = (state_q == ST_IDLE);
    assign OE = ~(in_access & ~wr_q);
    assign WE = ~(in_access &  wr_q);

`ifdef SRAM_CTRL_BYTE_EN
    assign LB = CE | ~be_q[0];
    assign UB = CE | ~be_q[1];
`else
    assign LB = CE;
    assign UB = CE;
`endif

    assign ADDR = {{ADDR_EXT_W{1'b0}}, addr_q};

    // Write data is driven from SETUP through DONE (setup and hold around
    // WE). Reads never drive, so DQ is never driven while OE is low.
    assign dq_oe = wr_q & (state_q != ST_IDLE);
    assign DQ    = dq_oe ? wdata_q : 16'hzzzz;

    assign RData = rdata_q;
    assign Ready = (state_q == ST_DONE);
    assign Busy  = (state_q != ST_IDLE);

    assign dbg_state_o = state_q;
    assign dbg_dq_oe_o = dq_oe;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl
//   Directed bench for sram_ctrl. Three controller instances (WAIT_STATES
//   1, 3 and 4) share the clock, reset and request fields; each has its own
//   Req and its own behavioural asynchronous SRAM on a private DQ net.
//   Expected values are hand-computed constants from the cycle timing
//   (accept at edge 0, Ready in cycle WAIT_STATES+2).
module tb_sram_ctrl;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] WData;
`ifdef SRAM_CTRL_BYTE_EN
    logic [1:0]  ByteEn;
`endif
    logic req1, req3, req4;

    logic [15:0] rdata1, rdata3, rdata4;
    logic        ready1, ready3, ready4;
    logic        busy1, busy3, busy4;
    logic        ce1, oe1, we1, lb1, ub1;
    logic        ce3, oe3, we3, lb3, ub3;
    logic        ce4, oe4, we4, lb4, ub4;
    logic [19:0] adr1, adr3, adr4;
    wire  [15:0] dq1, dq3, dq4;
    logic [1:0]  st1, st3, st4;
    logic        doe1, doe3, doe4;

    int vectors     = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    sram_ctrl #(.WAIT_STATES(1)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Req(req1), .Wr(Wr), .Addr(Addr), .WData(WData),
`ifdef SRAM_CTRL_BYTE_EN
        .ByteEn(ByteEn),
`endif
        .RData(rdata1), .Ready(ready1), .Busy(busy1),
        .CE(ce1), .OE(oe1), .WE(we1), .LB(lb1), .UB(ub1),
        .ADDR(adr1), .DQ(dq1), .dbg_state_o(st1), .dbg_dq_oe_o(doe1)
    );

    sram_ctrl #(.WAIT_STATES(3)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .Req(req3), .Wr(Wr), .Addr(Addr), .WData(WData),
`ifdef SRAM_CTRL_BYTE_EN
        .ByteEn(ByteEn),
`endif
        .RData(rdata3), .Ready(ready3), .Busy(busy3),
        .CE(ce3), .OE(oe3), .WE(we3), .LB(lb3), .UB(ub3),
        .ADDR(adr3), .DQ(dq3), .dbg_state_o(st3), .dbg_dq_oe_o(doe3)
    );

    sram_ctrl #(.WAIT_STATES(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .Req(req4), .Wr(Wr), .Addr(Addr), .WData(WData),
`ifdef SRAM_CTRL_BYTE_EN
        .ByteEn(ByteEn),
`endif
        .RData(rdata4), .Ready(ready4), .Busy(busy4),
        .CE(ce4), .OE(oe4), .WE(we4), .LB(lb4), .UB(ub4),
        .ADDR(adr4), .DQ(dq4), .dbg_state_o(st4), .dbg_dq_oe_o(doe4)
    );

    // ------------------------------------------------------------------
    // Asynchronous SRAM models (256 words each, low address bits)
    // ------------------------------------------------------------------
    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    logic [15:0] mem4 [0:255];

    assign dq1 = (!ce1 && !oe1) ? mem1[adr1[7:0]] : 16'hzzzz;
    assign dq3 = (!ce3 && !oe3) ? mem3[adr3[7:0]] : 16'hzzzz;
    assign dq4 = (!ce4 && !oe4) ? mem4[adr4[7:0]] : 16'hzzzz;

    always @(posedge we1) if (!ce1) begin
        if (!lb1) mem1[adr1[7:0]][7:0]  <= dq1[7:0];
        if (!ub1) mem1[adr1[7:0]][15:8] <= dq1[15:8];
    end
    always @(posedge we3) if (!ce3) begin
        if (!lb3) mem3[adr3[7:0]][7:0]  <= dq3[7:0];
        if (!ub3) mem3[adr3[7:0]][15:8] <= dq3[15:8];
    end
    always @(posedge we4) if (!ce4) begin
        if (!lb4) mem4[adr4[7:0]][7:0]  <= dq4[7:0];
        if (!ub4) mem4[adr4[7:0]][15:8] <= dq4[15:8];
    end

    // ------------------------------------------------------------------
    // Protocol monitors
    // ------------------------------------------------------------------
    logic mon_en = 1'b0;
    int   we_fall1 = 0;
    int   oe_fall1 = 0;
    int   viol     = 0;

    always @(negedge we1) if (mon_en) we_fall1++;
    always @(negedge oe1) if (mon_en) oe_fall1++;

    always @(negedge Clk) if (mon_en) begin
        if (!oe1 && !we1) viol++;
        if (!oe3 && !we3) viol++;
        if (!oe4 && !we4) viol++;
        if (doe1 && !oe1) viol++;
        if (doe3 && !oe3) viol++;
        if (doe4 && !oe4) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int w, input logic v);
        case (w)
            1:       req1 = v;
            3:       req3 = v;
            default: req4 = v;
        endcase
    endtask

    task automatic sample(input int w, output logic rdy, output logic o,
                          output logic e, output logic d);
        case (w)
            1:       begin rdy = ready1; o = oe1; e = we1; d = doe1; end
            3:       begin rdy = ready3; o = oe3; e = we3; d = doe3; end
            default: begin rdy = ready4; o = oe4; e = we4; d = doe4; end
        endcase
    endtask

    // One-cycle Req pulse, then wait (bounded) for Ready. lat is the cycle
    // index of Ready counting the SETUP cycle as 1; 0 means timeout. Returns
    // in the IDLE cycle following DONE.
    task automatic do_access(input int w, input logic wr, input logic [15:0] a,
                             input logic [15:0] d, input logic [1:0] be,
                             output int lat, output int oe_n, output int we_n,
                             output int drv_rd);
        logic rdy, o, e, doe;
        Wr    = wr;
        Addr  = a;
        WData = d;
`ifdef SRAM_CTRL_BYTE_EN
        ByteEn = be;
`endif
        set_req(w, 1'b1);
        step();
        set_req(w, 1'b0);
        lat = 0; oe_n = 0; we_n = 0; drv_rd = 0;
        for (int c = 1; c <= 30; c++) begin
            sample(w, rdy, o, e, doe);
            if (!o) oe_n++;
            if (!e) we_n++;
            if (!wr && doe) drv_rd++;
            if (rdy) begin
                lat = c;
                break;
            end
            step();
        end
        step();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int lat, oe_n, we_n, drv, base_we, base_oe;

        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0000;
            mem3[i] = 16'h0000;
            mem4[i] = 16'h0000;
        end
        mem1[8'h01] = 16'h1111;
        mem1[8'h02] = 16'h2222;
        mem1[8'h40] = 16'h1234;
        mem3[8'h31] = 16'h5A5A;
        mem4[8'h20] = 16'h1234;

        Reset = 1'b1; Wr = 1'b0; Addr = 16'h0; WData = 16'h0;
`ifdef SRAM_CTRL_BYTE_EN
        ByteEn = 2'b11;
`endif
        req1 = 1'b0; req3 = 1'b0; req4 = 1'b0;
        step(); step();
        Reset = 1'b0;
        step();
        mon_en = 1'b1;

        // 1. reset / idle state
        check("rst_strobes1", {27'd0, ce1, oe1, we1, lb1, ub1}, 32'h1F);
        check("rst_strobes3", {27'd0, ce3, oe3, we3, lb3, ub3}, 32'h1F);
        check("rst_strobes4", {27'd0, ce4, oe4, we4, lb4, ub4}, 32'h1F);
        check("rst_dq_drive", {29'd0, doe1, doe3, doe4}, 32'h0);
        check("rst_rdata", {16'd0, rdata1}, 32'h0);
        check("rst_ready_busy", {26'd0, ready1, ready3, ready4, busy1, busy3, busy4}, 32'h0);
        check("rst_addr", {12'd0, adr1}, 32'h0);
        check("rst_state", {30'd0, st1}, 32'd0);

        // 2. write 0xBEEF @0x0010 then read back (WAIT_STATES = 1)
        base_we = we_fall1;
        do_access(1, 1'b1, 16'h0010, 16'hBEEF, 2'b11, lat, oe_n, we_n, drv);
        check("t2_wr_latency", lat, 3);
        check("t2_we_cycles", we_n, 1);
        check("t2_we_edges", we_fall1 - base_we, 1);
        check("t2_wr_oe_cycles", oe_n, 0);
        check("t2_mem", {16'd0, mem1[8'h10]}, 32'hBEEF);
        do_access(1, 1'b0, 16'h0010, 16'h0000, 2'b11, lat, oe_n, we_n, drv);
        check("t2_rd_latency", lat, 3);
        check("t2_rd_oe_cycles", oe_n, 1);
        check("t2_rdata", {16'd0, rdata1}, 32'hBEEF);
        check("t2_rd_no_drive", drv, 0);
        // a write must not disturb RData
        do_access(1, 1'b1, 16'h0011, 16'h7777, 2'b11, lat, oe_n, we_n, drv);
        check("t2_rdata_kept", {16'd0, rdata1}, 32'hBEEF);

        // 3. WAIT_STATES = 4 read of 0x1234
        do_access(4, 1'b0, 16'h0020, 16'h0000, 2'b11, lat, oe_n, we_n, drv);
        check("t3_latency", lat, 6);
        check("t3_oe_cycles", oe_n, 4);
        check("t3_rdata", {16'd0, rdata4}, 32'h1234);
        check("t3_no_drive", drv, 0);
        check("t3_addr", {12'd0, adr4}, 32'h20);
        check("t3_idle", {29'd0, busy4, st4}, 32'h0);

        // 4. Req held high: back-to-back reads with one IDLE gap
        base_oe = oe_fall1;
        Wr = 1'b0; Addr = 16'h0001; req1 = 1'b1;
        step();                                 // cycle 1: SETUP
        check("t4_busy_c1", {31'd0, busy1}, 32'd1);
        Addr = 16'h0002;
        step(); step();                         // cycle 3: DONE
        check("t4_ready_c3", {31'd0, ready1}, 32'd1);
        check("t4_rdata1", {16'd0, rdata1}, 32'h1111);
        step();                                 // cycle 4: IDLE gap
        check("t4_idle_gap", {29'd0, busy1, st1}, 32'h0);
        step();                                 // cycle 5: second SETUP
        check("t4_second_accept", {31'd0, busy1}, 32'd1);
        check("t4_addr2", {12'd0, adr1}, 32'h2);
        req1 = 1'b0;
        step();                                 // cycle 6: ACCESS
        req1 = 1'b1;
        step();                                 // cycle 7: DONE
        check("t4_ready_c7", {31'd0, ready1}, 32'd1);
        check("t4_rdata2", {16'd0, rdata1}, 32'h2222);
        req1 = 1'b0;
        step(); step(); step();
        check("t4_settled", {31'd0, busy1}, 32'd0);
        check("t4_access_count", oe_fall1 - base_oe, 2);

        // 5. reset in the second ACCESS cycle of a WAIT_STATES = 3 write
        Wr = 1'b1; Addr = 16'h0030; WData = 16'hCAFE; req3 = 1'b1;
        step();                                 // cycle 1: SETUP
        req3 = 1'b0;
        step(); step();                         // cycle 3: ACCESS #2
        check("t5_in_access", {30'd0, st3}, 32'd2);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t5_strobes", {27'd0, ce3, oe3, we3, lb3, ub3}, 32'h1F);
        check("t5_dq_drive", {31'd0, doe3}, 32'd0);
        check("t5_ready_busy", {30'd0, ready3, busy3}, 32'd0);
        check("t5_addr", {12'd0, adr3}, 32'h0);
        do_access(3, 1'b0, 16'h0031, 16'h0000, 2'b11, lat, oe_n, we_n, drv);
        check("t5_rd_latency", lat, 5);
        check("t5_rd_oe_cycles", oe_n, 3);
        check("t5_rdata", {16'd0, rdata3}, 32'h5A5A);

`ifdef SRAM_CTRL_BYTE_EN
        // 6. byte lanes: upper-lane write, then full and lower-lane reads
        do_access(1, 1'b1, 16'h0040, 16'hAB00, 2'b10, lat, oe_n, we_n, drv);
        check("t6_mem", {16'd0, mem1[8'h40]}, 32'hAB34);
        do_access(1, 1'b0, 16'h0040, 16'h0000, 2'b11, lat, oe_n, we_n, drv);
        check("t6_rd_word", {16'd0, rdata1}, 32'hAB34);
        do_access(1, 1'b0, 16'h0040, 16'h0000, 2'b01, lat, oe_n, we_n, drv);
        check("t6_rd_lo", {16'd0, rdata1}, 32'h0034);
        check("t6_idle_lanes", {30'd0, lb1, ub1}, 32'h3);
`endif

        check("protocol_violations", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
